// File: rtl/mem_port_arbiter.sv
// Arbitrates one external memory port between instruction fetch and data access.
// Data wins by default; a burst limit forces an instruction grant to prevent starvation.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_BURST = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we_re,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_mask,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        m_request,
    output logic        m_we_re,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_mask,
    input  logic        m_valid,
    input  logic [31:0] m_rdata,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } state_t;

    localparam logic [3:0]  BURST_MAX = 4'(MAX_D_BURST);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_burst;
    logic [15:0] r_tcnt;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_tmo;
    logic        w_done;

    assign w_grant_d = d_req && (!i_req || (r_burst < BURST_MAX));
    assign w_grant_i = !w_grant_d && i_req;
    // The busy phase ends on the TIMEOUT-th cycle without a response.
    assign w_tmo     = (TIMEOUT != 0) && (r_tcnt == TMO_LAST);
    assign w_done    = m_valid || w_tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next_state = BUSY_D;
                end else if (w_grant_i) begin
                    w_next_state = BUSY_I;
                end
            end
            BUSY_I: if (w_done) w_next_state = RESP_I;
            BUSY_D: if (w_done) w_next_state = RESP_D;
            RESP_I: w_next_state = IDLE;
            RESP_D: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_request   <= 1'b0;
            m_we_re     <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_mask      <= '0;
            i_valid     <= 1'b0;
            i_rdata     <= '0;
            d_valid     <= 1'b0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
            r_burst     <= '0;
            r_tcnt      <= '0;
        end else begin
            i_valid     <= 1'b0;
            d_valid     <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tcnt <= '0;
                    // Only data grants made while fetch waits count toward the burst.
                    if (!i_req) begin
                        r_burst <= '0;
                    end else if (w_grant_d) begin
                        r_burst <= (r_burst == BURST_MAX) ? r_burst : r_burst + 4'd1;
                    end else if (w_grant_i) begin
                        r_burst <= '0;
                    end
                    if (w_grant_d) begin
                        m_request <= 1'b1;
                        m_we_re   <= d_we_re;
                        m_addr    <= d_addr;
                        m_wdata   <= d_wdata;
                        m_mask    <= d_mask;
                    end else if (w_grant_i) begin
                        m_request <= 1'b1;
                        m_we_re   <= 1'b0;
                        m_addr    <= i_addr;
                        m_wdata   <= '0;
                        m_mask    <= 4'hF;
                    end
                end
                BUSY_I: begin
                    if (m_valid) begin
                        m_request <= 1'b0;
                        i_valid   <= 1'b1;
                        i_rdata   <= m_rdata;
                    end else if (w_tmo) begin
                        m_request   <= 1'b0;
                        i_valid     <= 1'b1;
                        i_rdata     <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                BUSY_D: begin
                    if (m_valid) begin
                        m_request <= 1'b0;
                        d_valid   <= 1'b1;
                        if (!m_we_re) begin
                            d_rdata <= m_rdata;
                        end
                    end else if (w_tmo) begin
                        m_request   <= 1'b0;
                        d_valid     <= 1'b1;
                        d_rdata     <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory requests
// and responses; a negedge monitor checks them as the DUT presents them.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;
    localparam int TMO  = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        tmo;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we_re;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_request;
    logic        m_we_re;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_mask;
    logic        m_valid;
    logic [31:0] m_rdata;
    logic        timeout_err;

    int   total = 0;
    int   bad   = 0;
    req_t exp_req[$];
    rsp_t exp_rsp[$];
    logic prev_mreq = 1'b0;

    mem_port_arbiter #(.MAX_D_BURST(MAXB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we_re(d_we_re), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mask(d_mask), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_request(m_request), .m_we_re(m_we_re), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_mask(m_mask), .m_valid(m_valid), .m_rdata(m_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void push_i(input logic [31:0] addr, input logic [31:0] data);
        exp_req.push_back('{we: 1'b0, addr: addr, wdata: 32'd0, mask: 4'hF});
        exp_rsp.push_back('{is_d: 1'b0, rdata: data, tmo: 1'b0});
    endfunction

    function automatic void push_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] mask, input logic [31:0] rdata, input logic tmo);
        exp_req.push_back('{we: we, addr: addr, wdata: wdata, mask: mask});
        exp_rsp.push_back('{is_d: 1'b1, rdata: rdata, tmo: tmo});
    endfunction

    // Memory model: wait (bounded) for a request, answer it in the same cycle it is seen.
    task automatic serve(input logic [31:0] data);
        int n = 0;
        while (!m_request && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("serve_wait_m_request", {79'd0, m_request}, 80'd1);
        m_valid = 1'b1;
        m_rdata = data;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_rdata = 32'd0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (m_request && !prev_mreq) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_m_request", {11'd0, m_we_re, m_addr, m_wdata, m_mask}, 80'd0);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    $display("req: we=%0b addr=%h wdata=%h mask=%h", m_we_re, m_addr, m_wdata, m_mask);
                    chk("m_fields", {11'd0, m_we_re, m_addr, m_wdata, m_mask}, {11'd0, e});
                end
            end
            if (i_valid && d_valid) begin
                chk("both_valid", 80'd1, 80'd0);
            end
            if (i_valid || d_valid) begin
                logic [31:0] rd;
                rd = d_valid ? d_rdata : i_rdata;
                $display("rsp: %s rdata=%h tmo=%0b", d_valid ? "D" : "I", rd, timeout_err);
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_valid", {46'd0, d_valid, rd, timeout_err}, 80'd0);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("response", {46'd0, d_valid, rd, timeout_err}, {46'd0, r});
                end
            end else if (timeout_err) begin
                chk("timeout_err_without_valid", 80'd1, 80'd0);
            end
        end
        prev_mreq = m_request;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b0; i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we_re = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_mask = 4'd0;
        m_valid = 1'b0; m_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {75'd0, m_request, m_we_re, i_valid, d_valid, timeout_err}, 80'd0);
        chk("rst_mfields", {12'd0, m_addr, m_wdata, m_mask}, 80'd0);
        chk("rst_rdata", {16'd0, i_rdata, d_rdata}, 80'd0);
        rst = 1'b1;
        gap(1);

        // single fetch
        push_i(32'h100, 32'h0050_0093);
        i_req = 1'b1; i_addr = 32'h100;
        serve(32'h0050_0093);
        i_req = 1'b0;
        gap(2);

        // single store: memory returns junk that must not reach d_rdata
        push_d(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011, 32'd0, 1'b0);
        d_req = 1'b1; d_we_re = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_mask = 4'b0011;
        serve(32'hFFFF_FFFF);
        d_req = 1'b0; d_we_re = 1'b0;
        gap(2);

        // single load
        push_d(1'b0, 32'h2008, 32'd0, 4'hF, 32'hCAFE_F00D, 1'b0);
        d_req = 1'b1; d_addr = 32'h2008; d_wdata = 32'd0; d_mask = 4'hF;
        serve(32'hCAFE_F00D);
        d_req = 1'b0;
        gap(2);

        // contention: expected grant order D,D,D,D,I repeating
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) push_i(32'h200, 32'h5000_0000 + k);
            else push_d(1'b0, 32'h3000, 32'd0, 4'hF, 32'h5000_0000 + k, 1'b0);
        end
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_addr = 32'h3000; d_mask = 4'hF;
        for (int k = 0; k < 10; k++) begin
            serve(32'h5000_0000 + k);
        end
        i_req = 1'b0; d_req = 1'b0;
        gap(2);

        // timeout: memory stays silent
        push_d(1'b0, 32'h4000, 32'd0, 4'hC, 32'd0, 1'b1);
        d_req = 1'b1; d_addr = 32'h4000; d_mask = 4'hC;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (m_request) cnt++;
            else if (cnt > 0) break;
        end
        d_req = 1'b0;
        chk("timeout_request_cycles", 80'(cnt), 80'(TMO));
        gap(1);

        // recovery after timeout
        push_d(1'b0, 32'h4004, 32'd0, 4'hF, 32'h600D_F00D, 1'b0);
        d_req = 1'b1; d_addr = 32'h4004; d_mask = 4'hF;
        serve(32'h600D_F00D);
        d_req = 1'b0;
        gap(2);

        // spurious m_valid in IDLE
        m_valid = 1'b1; m_rdata = 32'h1234_5678;
        gap(1);
        m_valid = 1'b0; m_rdata = 32'd0;
        gap(2);
        chk("spurious_i_rdata", {48'd0, i_rdata}, {48'd0, 32'h5000_0009});
        chk("spurious_d_rdata", {48'd0, d_rdata}, {48'd0, 32'h600D_F00D});

        // reset while BUSY_I, then re-grant of the held fetch
        exp_req.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'd0, mask: 4'hF});
        push_i(32'h400, 32'h0000_0413);
        i_req = 1'b1; i_addr = 32'h400;
        cnt = 0;
        while (!m_request && cnt < 30) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_m_request", {79'd0, m_request}, 80'd0);
        chk("async_rst_ctrl", {76'd0, i_valid, d_valid, timeout_err, m_we_re}, 80'd0);
        chk("async_rst_mfields", {12'd0, m_addr, m_wdata, m_mask}, 80'd0);
        chk("async_rst_rdata", {16'd0, i_rdata, d_rdata}, 80'd0);
        @(negedge clk);
        rst = 1'b1;
        m_valid = 1'b1; m_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_rdata = 32'd0;
        serve(32'h0000_0413);
        i_req = 1'b0;
        gap(3);

        chk("req_queue_drained", 80'(exp_req.size()), 80'd0);
        chk("rsp_queue_drained", 80'(exp_rsp.size()), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
